// File: rtl/dmem_bridge.sv
// dmem_bridge: core data port to 16-bit halfword memory with req/ack handshake and timeout
module dmem_bridge #(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [31:0]       dAddress,
  input  logic [31:0]       dDataIn,
  input  logic              dWrite,
  input  logic              dRead,
  input  logic              d32bit,
  input  logic [31:0]       baseAddress,
  output logic [31:0]       dDataOut,
  output logic              externalStall,
  output logic              dBusError,
  output logic [ADDR_W-1:0] mAddr,
  output logic [15:0]       mWData,
  output logic              mWE,
  output logic              mReq,
  input  logic [15:0]       mRData,
  input  logic              mAck
);
  typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pa;
  logic [31:0] data, rdata, dout_q;
  logic [7:0] cnt;
  logic wide, op_write, err, req, busy, tmo;
  assign req  = dRead | dWrite;
  assign busy = (state == HI) || (state == LO);
  assign tmo  = busy && !mAck && (cnt == 8'(TIMEOUT - 1));
  always_ff @(posedge clk or posedge Reset)
    if (Reset) state <= IDLE;
    else       state <= state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (req ? HI : IDLE) :
              (state == HI)   ? (mAck ? (wide ? LO : DONE) : (tmo ? DONE : HI)) :
              (state == LO)   ? ((mAck || tmo) ? DONE : LO) : IDLE;
  end
  assign mReq          = busy;
  assign mWE           = busy & op_write;
  assign mAddr         = (state == LO) ? pa + ADDR_W'(1) : pa;
  assign mWData        = (state == HI && wide) ? data[31:16] : data[15:0];
  assign externalStall = !Reset && ((state == IDLE) ? req : busy);
  assign dDataOut      = (state == DONE) ? rdata : dout_q;
  assign dBusError     = (state == DONE) & err;
  // rdata is cleared at request start so writes and timeouts present zero in DONE
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      pa       <= '0;
      data     <= '0;
      rdata    <= '0;
      dout_q   <= '0;
      cnt      <= '0;
      wide     <= 1'b0;
      op_write <= 1'b0;
      err      <= 1'b0;
    end else if (state == IDLE) begin
      if (req) begin
        pa       <= ADDR_W'(dAddress + baseAddress);
        data     <= dDataIn;
        wide     <= d32bit;
        op_write <= dWrite;
        cnt      <= '0;
        err      <= 1'b0;
        rdata    <= '0;
      end
    end else if (busy) begin
      if (mAck) begin
        cnt <= '0;
        if (!op_write)
          rdata <= (state == LO) ? {rdata[31:16], mRData} :
                   wide ? {mRData, rdata[15:0]} : {16'h0, mRData};
      end else if (tmo) begin
        err   <= 1'b1;
        rdata <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end else begin
      dout_q <= rdata;
    end
  end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: table-driven and randomized checks of dmem_bridge against a transaction-level model
module tb_dmem_bridge;
  localparam int TO = 4;
  localparam int MASK = 32'h00FF_FFFF;
  logic clk = 1'b0;
  logic Reset;
  logic [31:0] dAddress, dDataIn, baseAddress, dDataOut;
  logic dWrite, dRead, d32bit, externalStall, dBusError, mWE, mReq, mAck;
  logic [23:0] mAddr;
  logic [15:0] mWData, mRData;
  int tests = 0;
  int fails = 0;

  dmem_bridge #(.ADDR_W(24), .TIMEOUT(TO)) dut (
    .clk(clk), .Reset(Reset), .dAddress(dAddress), .dDataIn(dDataIn), .dWrite(dWrite),
    .dRead(dRead), .d32bit(d32bit), .baseAddress(baseAddress), .dDataOut(dDataOut),
    .externalStall(externalStall), .dBusError(dBusError), .mAddr(mAddr), .mWData(mWData),
    .mWE(mWE), .mReq(mReq), .mRData(mRData), .mAck(mAck)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a, b, d;
    logic        w32, rd, wr;
    int          w0, w1;
    logic [15:0] r0, r1;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called in an IDLE cycle; returns in the IDLE cycle after DONE.
  task automatic access(input vec_t v);
    int pa, addr, waits, stalls, exp_stalls, c;
    logic t0, t1, ack;
    logic [31:0] exp_out;
    logic [15:0] exp_wd;
    pa = (v.a + v.b) & MASK;
    t0 = (v.w0 >= TO);
    t1 = v.w32 && !t0 && (v.w1 >= TO);
    exp_stalls = 1 + (t0 ? TO : v.w0 + 1) + ((v.w32 && !t0) ? (t1 ? TO : v.w1 + 1) : 0);
    exp_out = (v.wr || t0 || t1) ? 32'h0 : v.w32 ? {v.r0, v.r1} : {16'h0, v.r0};
    dAddress = v.a; baseAddress = v.b; dDataIn = v.d; d32bit = v.w32;
    dRead = v.rd; dWrite = v.wr; mAck = 1'b0;
    #1;
    chk("idle_stall", {31'h0, externalStall}, 32'h1);
    chk("idle_req", {31'h0, mReq}, 32'h0);
    stalls = 1;
    @(posedge clk); #1;
    for (int ph = 0; ph < (v.w32 ? 2 : 1); ph++) begin
      waits = ph ? v.w1 : v.w0;
      addr = ph ? (pa + 1) & MASK : pa;
      exp_wd = (ph == 0 && v.w32) ? v.d[31:16] : v.d[15:0];
      c = 0;
      ack = 1'b0;
      while (1) begin
        chk("req", {31'h0, mReq}, 32'h1);
        chk("addr", {8'h0, mAddr}, addr);
        chk("wdata", {16'h0, mWData}, {16'h0, exp_wd});
        chk("we", {31'h0, mWE}, {31'h0, v.wr});
        stalls += externalStall ? 1 : 0;
        ack = (c == waits);
        mAck = ack;
        mRData = ack ? (ph ? v.r1 : v.r0) : 16'($urandom);
        @(posedge clk); #1;
        mAck = 1'b0;
        mRData = 16'($urandom);
        if (ack || c == TO - 1) break;
        c++;
      end
      if (!ack) break;
    end
    chk("stall_cycles", stalls, exp_stalls);
    chk("done_stall", {31'h0, externalStall}, 32'h0);
    chk("done_req", {31'h0, mReq}, 32'h0);
    chk("done_data", dDataOut, exp_out);
    chk("done_err", {31'h0, dBusError}, {31'h0, t0 || t1});
    mAck = 1'b1;
    dRead = 1'b0; dWrite = 1'b0;
    @(posedge clk); #1;
    mAck = 1'b0;
    #1;
    chk("idle_req_after", {31'h0, mReq}, 32'h0);
    chk("hold_data", dDataOut, exp_out);
    chk("idle_err", {31'h0, dBusError}, 32'h0);
  endtask

  initial begin
    vt[0] = '{32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 0, 16'hBEEF, 16'h0};
    vt[1] = '{32'h20, 32'h100, 32'h12345678, 1'b1, 1'b0, 1'b1, 1, 1, 16'h0, 16'h0};
    vt[2] = '{32'hFFFFFF, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 0, 2, 16'hCAFE, 16'hF00D};
    vt[3] = '{32'h40, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 99, 0, 16'h1234, 16'h0};
    vt[4] = '{32'h50, 32'h0, 32'hA5A55A5A, 1'b0, 1'b1, 1'b1, 0, 0, 16'h7777, 16'h0};
    vt[5] = '{32'h60, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, TO - 1, 0, 16'h1111, 16'h2222};
    vt[6] = '{32'h70, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 0, TO, 16'hABCD, 16'h9999};
    vt[7] = '{32'h00FFFFF0, 32'hFF000020, 32'h0, 1'b0, 1'b1, 1'b0, 2, 0, 16'h4321, 16'h0};
    Reset = 1'b1;
    dAddress = 32'h0; baseAddress = 32'h0; dDataIn = 32'h0;
    dRead = 1'b1; dWrite = 1'b0; d32bit = 1'b0; mAck = 1'b0; mRData = 16'h0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_stall", {31'h0, externalStall}, 32'h0);
    chk("rst_req", {31'h0, mReq}, 32'h0);
    chk("rst_we", {31'h0, mWE}, 32'h0);
    chk("rst_addr", {8'h0, mAddr}, 32'h0);
    chk("rst_wdata", {16'h0, mWData}, 32'h0);
    chk("rst_data", dDataOut, 32'h0);
    chk("rst_err", {31'h0, dBusError}, 32'h0);
    dRead = 1'b0;
    Reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) access(vt[i]);
    // reset in the low-half phase must abort immediately
    dAddress = 32'h300; baseAddress = 32'h0; d32bit = 1'b1; dRead = 1'b1;
    @(posedge clk); #1;
    mAck = 1'b1; mRData = 16'h5555;
    @(posedge clk); #1;
    mAck = 1'b0;
    chk("lo_req", {31'h0, mReq}, 32'h1);
    chk("lo_addr", {8'h0, mAddr}, 32'h301);
    Reset = 1'b1;
    #1;
    chk("rst_lo_req", {31'h0, mReq}, 32'h0);
    chk("rst_lo_stall", {31'h0, externalStall}, 32'h0);
    chk("rst_lo_data", dDataOut, 32'h0);
    dRead = 1'b0;
    @(posedge clk); #1;
    Reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_req", {31'h0, mReq}, 32'h0);
    chk("post_rst_stall", {31'h0, externalStall}, 32'h0);
    access(vt[2]);
    for (int i = 0; i < 80; i++) begin
      vec_t v;
      int op;
      op = $urandom_range(0, 2);
      v.a = $urandom; v.b = $urandom; v.d = $urandom;
      v.w32 = 1'($urandom_range(0, 1));
      v.rd = (op != 1); v.wr = (op != 0);
      v.w0 = $urandom_range(0, TO + 1); v.w1 = $urandom_range(0, TO + 1);
      v.r0 = 16'($urandom); v.r1 = 16'($urandom);
      access(v);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
